// File: rtl/uds_pkg.sv
// Shared types and constants for the UDS job sequencer.
// FSM states, function-mode encodings and output FIFO depth.
package uds_pkg;

   typedef enum logic [2:0] {
      UDS_IDLE,
      UDS_LOAD,
      UDS_HOLD,
      UDS_GAP,
      UDS_DRAIN
   } uds_state_e;

   localparam logic [1:0] UDS_MODE_UP     = 2'b10;
   localparam logic [1:0] UDS_MODE_DN_MAX = 2'b00;
   localparam logic [1:0] UDS_MODE_DN_AVG = 2'b01;

   localparam int UDS_FIFO_DEPTH = 2;

endpackage

// File: rtl/uds_seq_ctrl_if.sv
// Job config, input tile, datapath and result buses of the sequencer.
// master = surrounding system, slave = sequencer.
interface uds_seq_ctrl_if #(
   parameter int A     = 64,
   parameter int DW    = 32,
   parameter int CNT_W = 16
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [1:0]            cfg_mode;
   logic [1:0]            cfg_scale;
   logic [CNT_W-1:0]      cfg_tiles;

   logic                  in_valid;
   logic                  in_ready;
   logic [A*DW-1:0]       in_data;

   logic [A*DW-1:0]       uds_idata;
   logic                  uds_idata_valid;
   logic                  uds_active;
   logic [1:0]            uds_function_mode;
   logic [1:0]            uds_scale_factor;
   logic [2*A*DW-1:0]     uds_odata;
   logic                  uds_odata_valid;

   logic                  out_valid;
   logic                  out_ready;
   logic [2*A*DW-1:0]     out_data;

   modport master (
      output cfg_valid, cfg_mode, cfg_scale, cfg_tiles,
      output in_valid, in_data,
      output uds_odata, uds_odata_valid,
      output out_ready,
      input  cfg_ready, in_ready,
      input  uds_idata, uds_idata_valid, uds_active,
      input  uds_function_mode, uds_scale_factor,
      input  out_valid, out_data
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_scale, cfg_tiles,
      input  in_valid, in_data,
      input  uds_odata, uds_odata_valid,
      input  out_ready,
      output cfg_ready, in_ready,
      output uds_idata, uds_idata_valid, uds_active,
      output uds_function_mode, uds_scale_factor,
      output out_valid, out_data
   );

endinterface

// File: rtl/uds_out_fifo.sv
// Two-entry result FIFO with registered storage and no bypass.
// A push into a full FIFO is accepted only alongside a pop.
module uds_out_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [1:0]   o_count,
   output logic [W-1:0] o_head
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop && (r_cnt != 2'd0);
   assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= ~r_wp;
         end
         if (w_pop)
            r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rp];

endmodule

// File: rtl/uds_seq_ctrl.sv
// UDS job sequencer: LOAD-HOLD-GAP tile slots, credit-limited
// launches against a 2-entry output FIFO, valid/ready result port.
module uds_seq_ctrl
   import uds_pkg::*;
#(
   parameter int A     = 64,
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   uds_seq_ctrl_if.slave  bus,
   output logic           busy,
   output logic           done,
   output logic           err_spurious
);

   localparam int OW = 2 * A * DW;

   uds_state_e       r_state;
   uds_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [1:0]       r_inflight;
   logic [1:0]       r_mode;
   logic [1:0]       r_scale;
   logic             r_done;
   logic             r_err;

   logic [1:0]       w_fifo_cnt;
   logic [OW-1:0]    w_fifo_head;
   logic             w_credit;
   logic             w_in_ready;
   logic             w_hs;
   logic             w_cfg_hs;
   logic             w_spur;
   logic             w_ret;
   logic             w_out_valid;
   logic             w_pop;
   logic             w_overflow;
   logic             w_push;
   logic             w_drain_ok;
   logic             w_done_set;

   // Tiles launched but not yet drained downstream may not exceed the FIFO
   assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_cnt})
                     < 3'(UDS_FIFO_DEPTH);

   assign w_in_ready  = (r_state == UDS_LOAD) && w_credit;
   assign w_hs        = bus.in_valid && w_in_ready;
   assign w_cfg_hs    = bus.cfg_valid && (r_state == UDS_IDLE);
   assign w_spur      = bus.uds_odata_valid && (r_inflight == 2'd0);
   assign w_ret       = bus.uds_odata_valid && !w_spur;
   assign w_out_valid = (w_fifo_cnt != 2'd0);
   assign w_pop       = w_out_valid && bus.out_ready;
   assign w_overflow  = w_ret && (w_fifo_cnt == 2'd2) && !w_pop;
   assign w_push      = w_ret && !w_overflow;
   assign w_drain_ok  = (r_inflight == 2'd0) && (w_fifo_cnt == 2'd0)
                        && !w_push;

   always_comb begin
      w_state_nxt = r_state;
      w_done_set  = 1'b0;
      unique case (r_state)
         UDS_IDLE: begin
            if (bus.cfg_valid) begin
               if (bus.cfg_tiles == '0)
                  w_done_set = 1'b1;
               else
                  w_state_nxt = UDS_LOAD;
            end
         end
         UDS_LOAD: begin
            if (w_hs)
               w_state_nxt = UDS_HOLD;
         end
         UDS_HOLD: w_state_nxt = UDS_GAP;
         UDS_GAP: begin
            if (r_remaining == CNT_W'(1))
               w_state_nxt = UDS_DRAIN;
            else
               w_state_nxt = UDS_LOAD;
         end
         UDS_DRAIN: begin
            if (w_drain_ok) begin
               w_done_set  = 1'b1;
               w_state_nxt = UDS_IDLE;
            end
         end
         default: w_state_nxt = UDS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= UDS_IDLE;
         r_remaining <= '0;
         r_inflight  <= 2'd0;
         r_mode      <= 2'd0;
         r_scale     <= 2'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_set;
         if (w_cfg_hs) begin
            r_mode      <= bus.cfg_mode;
            r_scale     <= bus.cfg_scale;
            r_remaining <= bus.cfg_tiles;
         end else if (r_state == UDS_GAP) begin
            r_remaining <= r_remaining - CNT_W'(1);
         end
         r_inflight <= r_inflight + {1'b0, w_hs} - {1'b0, w_ret};
         if (w_spur || w_overflow)
            r_err <= 1'b1;
      end
   end

   uds_out_fifo #(
      .W (OW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.uds_odata),
      .o_count (w_fifo_cnt),
      .o_head  (w_fifo_head)
   );

   // cfg_ready is masked during reset so every output reads 0 then
   assign bus.cfg_ready         = (r_state == UDS_IDLE) && !rst;
   assign bus.in_ready          = w_in_ready;
   assign bus.uds_idata         = bus.in_data;
   assign bus.uds_idata_valid   = w_hs;
   assign bus.uds_active        = (r_state == UDS_HOLD);
   assign bus.uds_function_mode = r_mode;
   assign bus.uds_scale_factor  = r_scale;
   assign bus.out_valid         = w_out_valid;
   assign bus.out_data          = w_fifo_head;

   assign busy         = (r_state != UDS_IDLE);
   assign done         = r_done;
   assign err_spurious = r_err;

endmodule

// File: tb/tb_uds_seq_ctrl.sv
// Scoreboard bench for uds_seq_ctrl with a behavioural datapath
// model, random tile data, random latency and random backpressure.
module tb_uds_seq_ctrl;
   import uds_pkg::*;

   localparam int A     = 64;
   localparam int DW    = 32;
   localparam int CNT_W = 16;
   localparam int IW    = A * DW;
   localparam int OW    = 2 * IW;

   logic clk;
   logic rst;
   logic busy;
   logic done;
   logic err_spurious;

   uds_seq_ctrl_if #(.A(A), .DW(DW), .CNT_W(CNT_W)) bus ();

   uds_seq_ctrl #(.A(A), .DW(DW), .CNT_W(CNT_W)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .err_spurious (err_spurious)
   );

   typedef struct {
      int            due;
      logic [OW-1:0] d;
   } dp_t;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   logic [OW-1:0] sb_q[$];
   dp_t           dp_q[$];
   int            hs_log[$];
   int            act_log[$];
   int            done_log[$];
   int            pops = 0;
   bit            seen_busy = 0;
   bit            seen_inready = 0;
   bit            spur_req = 0;
   int            or_mode = 1;
   int            iv_mode = 0;
   int            lat_fixed = 3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // The datapath doubles the tile: upper half inverted, lower half as is
   function automatic logic [OW-1:0] dp_fn(logic [IW-1:0] x);
      return {~x, x};
   endfunction

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Driver: tile data, in_valid, out_ready and datapath results
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < IW / 32; k++)
         bus.in_data[k*32 +: 32] = $urandom;
      bus.in_valid  = (iv_mode == 2) ? 1'($urandom_range(0, 1))
                                     : 1'(iv_mode);
      bus.out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1))
                                     : 1'(or_mode);
      bus.uds_odata_valid = 1'b0;
      if (rst) begin
         bus.uds_odata_valid = 1'b0;
      end else if (spur_req) begin
         bus.uds_odata_valid = 1'b1;
         bus.uds_odata       = {OW/32{32'hDEAD_BEEF}};
         spur_req            = 0;
      end else if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
         bus.uds_odata_valid = 1'b1;
         bus.uds_odata       = dp_q[0].d;
         void'(dp_q.pop_front());
      end
   end

   // Monitor: credit rule, in-order results, event logs
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (busy) seen_busy = 1;
         if (bus.in_ready) begin
            seen_inready = 1;
            chk("credit_outstanding_lt2", sb_q.size() < 2, 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            pops++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: result with empty scoreboard at cycle %0d",
                        cyc);
            end else begin
               logic [OW-1:0] e;
               e = sb_q.pop_front();
               if (bus.out_data !== e) begin
                  errors++;
                  $display("FAIL out_data: got low %h expected low %h (cycle %0d)",
                           bus.out_data[63:0], e[63:0], cyc);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            dp_t t;
            hs_log.push_back(cyc);
            t.due = cyc + ((lat_fixed > 0) ? lat_fixed
                                           : int'($urandom_range(1, 6)));
            t.d   = dp_fn(bus.in_data);
            dp_q.push_back(t);
            sb_q.push_back(t.d);
         end
         if (bus.uds_active) act_log.push_back(cyc);
         if (done) begin
            done_log.push_back(cyc);
            chk("done_cfg_ready", bus.cfg_ready, 1);
            chk("done_busy_low", busy, 0);
         end
      end
   end

   task automatic clear_logs();
      hs_log.delete();
      act_log.delete();
      done_log.delete();
      seen_busy    = 0;
      seen_inready = 0;
   endtask

   task automatic run_cfg(logic [1:0] m, logic [1:0] s,
                          int tiles, output int t);
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b1;
      bus.cfg_mode  = m;
      bus.cfg_scale = s;
      bus.cfg_tiles = CNT_W'(tiles);
      @(negedge clk);
      t = cyc;
      chk("cfg_accept", bus.cfg_ready, 1);
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic wait_done(int bound);
      int n0;
      int k;
      n0 = done_log.size();
      k  = 0;
      while (done_log.size() == n0 && k < bound) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("done_within_bound", done_log.size() > n0, 1);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_spurious, 0);
      chk({tag, "_cfg_ready"}, bus.cfg_ready, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_active"}, bus.uds_active, 0);
      chk({tag, "_idata_valid"}, bus.uds_idata_valid, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_mode"}, bus.uds_function_mode, 0);
      chk({tag, "_scale"}, bus.uds_scale_factor, 0);
   endtask

   initial begin
      int t;
      int p0;
      int n0;
      int nt;
      rst                 = 1'b1;
      bus.cfg_valid       = 1'b0;
      bus.cfg_mode        = 2'd0;
      bus.cfg_scale       = 2'd0;
      bus.cfg_tiles       = '0;
      bus.in_valid        = 1'b0;
      bus.in_data         = '0;
      bus.uds_odata       = '0;
      bus.uds_odata_valid = 1'b0;
      bus.out_ready       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_cfg_ready", bus.cfg_ready, 1);
      chk("post_reset_busy", busy, 0);

      // Basic 3-tile upsample job, fixed latency 3
      iv_mode   = 1;
      or_mode   = 1;
      lat_fixed = 3;
      clear_logs();
      p0 = pops;
      run_cfg(UDS_MODE_UP, 2'd0, 3, t);
      wait_done(100);
      chk("basic_hs_count", hs_log.size(), 3);
      chk("basic_act_count", act_log.size(), 3);
      for (int i = 0; i < 3 && i < hs_log.size(); i++)
         chk("basic_hs_cycle", hs_log[i] - t, 1 + 3 * i);
      for (int i = 0; i < 3 && i < act_log.size(); i++)
         chk("basic_active_cycle", act_log[i] - t, 2 + 3 * i);
      chk("basic_mode", bus.uds_function_mode, UDS_MODE_UP);
      chk("basic_pops", pops - p0, 3);
      chk("basic_done_count", done_log.size(), 1);
      repeat (2) @(negedge clk);
      chk("basic_busy_after", busy, 0);
      chk("basic_sb_empty", sb_q.size(), 0);

      // Zero-tile job
      clear_logs();
      run_cfg(UDS_MODE_DN_AVG, 2'd1, 0, t);
      repeat (5) @(negedge clk);
      chk("zero_done_count", done_log.size(), 1);
      if (done_log.size() > 0)
         chk("zero_done_cycle", done_log[0] - t, 1);
      chk("zero_busy_seen", seen_busy, 0);
      chk("zero_in_ready_seen", seen_inready, 0);

      // Backpressure: downstream stalled for 20 cycles
      clear_logs();
      p0        = pops;
      or_mode   = 0;
      lat_fixed = 2;
      run_cfg(UDS_MODE_DN_MAX, 2'd1, 4, t);
      repeat (20) @(negedge clk);
      #1;
      chk("bp_launches_capped", hs_log.size(), 2);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_scale", bus.uds_scale_factor, 1);
      or_mode = 1;
      wait_done(200);
      chk("bp_hs_total", hs_log.size(), 4);
      chk("bp_pops", pops - p0, 4);
      chk("bp_sb_empty", sb_q.size(), 0);

      // Random jobs: random in_valid, out_ready and datapath latency
      iv_mode   = 2;
      or_mode   = 2;
      lat_fixed = 0;
      for (int j = 0; j < 4; j++) begin
         clear_logs();
         p0 = pops;
         nt = (j == 0) ? 12 : int'($urandom_range(1, 9));
         run_cfg(2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)),
                 nt, t);
         wait_done(1500);
         chk("rand_hs_total", hs_log.size(), nt);
         chk("rand_pops", pops - p0, nt);
         chk("rand_sb_empty", sb_q.size(), 0);
         chk("rand_no_err", err_spurious, 0);
      end

      // Spurious datapath result while nothing is in flight
      iv_mode = 0;
      or_mode = 1;
      repeat (3) @(negedge clk);
      spur_req = 1;
      repeat (3) @(negedge clk);
      chk("spur_err_set", err_spurious, 1);
      chk("spur_no_push", bus.out_valid, 0);
      repeat (5) @(negedge clk);
      chk("spur_err_sticky", err_spurious, 1);
      chk("spur_sb_empty", sb_q.size(), 0);

      // Reset during HOLD of tile 2 of 5
      iv_mode   = 1;
      lat_fixed = 3;
      clear_logs();
      run_cfg(UDS_MODE_UP, 2'd1, 5, t);
      n0 = 0;
      while (act_log.size() < 2 && n0 < 100) begin
         @(negedge clk);
         #1;
         n0++;
      end
      chk("rst_reached_hold2", act_log.size(), 2);
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      sb_q.delete();
      dp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      n0  = done_log.size();
      repeat (10) @(negedge clk);
      chk("midrst_no_done", done_log.size(), n0);
      chk("midrst_idle", busy, 0);

      clear_logs();
      p0 = pops;
      run_cfg(UDS_MODE_DN_MAX, 2'd0, 3, t);
      wait_done(100);
      chk("after_rst_hs", hs_log.size(), 3);
      chk("after_rst_pops", pops - p0, 3);
      chk("after_rst_mode", bus.uds_function_mode, UDS_MODE_DN_MAX);
      chk("after_rst_err", err_spurious, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uds_seq_ctrl.md
# uds_seq_ctrl

Job sequencer for the UDS upsample/downsample datapath. It accepts a job descriptor (function mode, scale factor, tile count) and pulls tiles from the input buffer over valid/ready. It drives the datapath's `idata`/`idata_valid`/`active` in the fixed LOAD–HOLD–GAP slot pattern the datapath needs per tile. Because the datapath has no output backpressure, the block credits tile launches against a 2-entry output FIFO and presents results to the downstream writer over valid/ready.

## Interface
- `A`, 64 — elements per input tile (8×8); output tile is 2·A elements.
- `DW`, 32 — element width in bits.
- `CNT_W`, 16 — tile-count width.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `cfg_valid` in 1 — job descriptor valid.
- `cfg_ready` out 1 — high only in IDLE.
- `cfg_mode` in 2 — function_mode for the job: bit1=1 upsample; bit1=0 downsample; bit0 selects max (0) or avg (1).
- `cfg_scale` in 2 — scale_factor for the job (0 = 2×2, 1 = 3×3).
- `cfg_tiles` in CNT_W — number of tiles in the job.
- `in_valid` in 1 — input tile valid.
- `in_ready` out 1 — input tile accepted when both valid and ready are high.
- `in_data` in A·DW — input tile.
- `uds_idata` out A·DW — combinational pass-through of `in_data`.
- `uds_idata_valid` out 1 — equals `in_valid & in_ready`.
- `uds_active` out 1 — high in HOLD only.
- `uds_function_mode` out 2 — registered job config, stable for the whole job.
- `uds_scale_factor` out 2 — registered job config, stable for the whole job.
- `uds_odata` in 2·A·DW — datapath result.
- `uds_odata_valid` in 1 — datapath result valid.
- `out_valid` out 1 — result available.
- `out_ready` in 1 — downstream accepts result.
- `out_data` out 2·A·DW — FIFO head.
- `busy` out 1 — state ≠ IDLE.
- `done` out 1 — one-cycle pulse at job completion.
- `err_spurious` out 1 — sticky; set on `uds_odata_valid` while inflight==0; cleared only by `rst`.

## Operation
- FSM states: IDLE, LOAD, HOLD, GAP, DRAIN.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`: latch mode, scale, and `remaining`=`cfg_tiles`.
  - If `cfg_tiles`==0: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - `in_ready` = (inflight + fifo_count < 2).
  - On handshake: inflight += 1, go to HOLD. Without a handshake, stay in LOAD.
- HOLD: `uds_active`=1 for exactly one cycle, then go to GAP.
- GAP:
  - `uds_active`=0 for one cycle; `remaining` -= 1.
  - Go to DRAIN if `remaining` becomes 0, else go to LOAD.
- DRAIN: when inflight==0, fifo_count==0, and no push this cycle, pulse `done` and go to IDLE.
- Inflight counter (2 bits):
  - +1 on input handshake, −1 on `uds_odata_valid`.
  - Both in the same cycle: unchanged.
  - Decrement at 0: no change, set `err_spurious`, do not push the result.
- Output FIFO, depth 2:
  - Push `uds_odata` on `uds_odata_valid` (when not spurious).
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop on a full FIFO is legal.
  - The credit rule guarantees a push never meets a full FIFO without a pop. If it happens anyway, the data is dropped and `err_spurious` is set.
- `uds_function_mode`/`uds_scale_factor` update only on cfg acceptance.
- `cfg_valid` outside IDLE is ignored.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. `uds_idata` follows `in_data`.
- Reset mid-job: immediate abort; no `done`; the job is lost.

## Timing
- cfg accepted at cycle t → LOAD at t+1; earliest `in_ready` at t+1.
- Minimum tile period: 3 cycles (LOAD, HOLD, GAP). Back-to-back tiles: handshakes at t+1, t+4, t+7, …
- Datapath latency is not assumed; only the `uds_odata_valid` count is tracked.
- `out_valid` rises the cycle after the push; FIFO storage is registered, with no push-to-out bypass.
- `done` is asserted the cycle after DRAIN sees its exit condition, concurrent with the return to IDLE. `cfg_ready` is high in that same cycle.
- With `out_ready` held low, at most 2 tiles are launched; `in_ready` stays 0 until a pop frees a credit.

## Structure
- Package `uds_pkg`:
  - FSM state enum (`UDS_IDLE`, `UDS_LOAD`, `UDS_HOLD`, `UDS_GAP`, `UDS_DRAIN`).
  - Mode constants (`UDS_MODE_UP`=2'b10, `UDS_MODE_DN_MAX`=2'b00, `UDS_MODE_DN_AVG`=2'b01).
  - `UDS_FIFO_DEPTH`=2.
- Sub-module `uds_out_fifo`: parameterised width, depth 2. Ports: push/pop/count/head.

## Test plan
- **Basic job:** cfg_tiles=3, mode=2'b10, in_valid always high, out_ready high, model datapath returns valid 3 cycles after each load. Expect handshakes at t+1, t+4, t+7; `uds_active` high at t+2, t+5, t+8; three outputs in order; one `done` pulse; `busy` low afterwards.
- **Zero tiles:** cfg_tiles=0. Expect `done` at t+1, no `in_ready`, `busy` stays 0.
- **Backpressure:** cfg_tiles=4, out_ready=0 for 20 cycles. Expect exactly 2 loads, then `in_ready`=0; after out_ready=1, the remaining 2 tiles complete and outputs stay in order.
- **Simultaneous push/pop:** FIFO full and `uds_odata_valid` coincides with a pop. Expect count unchanged, data order preserved, no error.
- **Spurious output:** `uds_odata_valid` while inflight=0. Expect `err_spurious`=1 sticky, no FIFO push.
- **Reset mid-job:** `rst` pulsed during HOLD of tile 2 of 5. Expect all outputs 0 immediately, state IDLE, no `done`; a new job then runs normally.
